// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants for the pipelined CORDIC engine.
// Holds the 32-bit binary-angle arctangent table, the 1/K gain constant,
// the per-sample mode encoding and helpers that scale those constants
// to the configured angle/data widths.
package cordic_pkg;

  typedef enum logic {
    ROTATE = 1'b0,
    VECTOR = 1'b1
  } mode_e;

  // atan(2^-i) expressed as a 32-bit binary angle (2^32 == 2*pi)
  localparam logic [31:0] ATAN_TABLE [32] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
    32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
    32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
    32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
    32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
  };

  // 1/K as an unsigned 0.32 fraction (1/1.6467602 = 0.6072529)
  localparam logic [31:0] INV_K = 32'h9B74EDA8;

  // atan_i scaled to a zw-bit binary angle, rounded
  function automatic logic [31:0] atan_zw(input int unsigned idx, input int unsigned zw);
    logic [63:0] v;
    v = {32'd0, ATAN_TABLE[idx[4:0]]};
    if (zw >= 32'd32) begin
      v = v;
    end else begin
      v = (v + (64'd1 << (32'd31 - zw))) >> (32'd32 - zw);
    end
    return v[31:0];
  endfunction

  // round(2^width / K), used by the optional unity-gain stage
  function automatic logic [31:0] gain_const(input int unsigned width);
    logic [63:0] v;
    v = {32'd0, INV_K};
    if (width >= 32'd32) begin
      v = v;
    end else begin
      v = (v + (64'd1 << (32'd31 - width))) >> (32'd32 - width);
    end
    return v[31:0];
  endfunction

endpackage

// File: rtl/cordic_pipe_stage.sv
// cordic_stage: one CORDIC micro-rotation with its own pipeline register.
// Direction comes from the sign of z (rotation) or y (vectoring); the
// whole register, including valid and mode, advances only when en_i is high.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int XW  = 18,
  parameter int ZW  = 16,
  parameter int IDX = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic                 valid_i,
  input  logic                 mode_i,
  input  logic signed [XW-1:0] x_i,
  input  logic signed [XW-1:0] y_i,
  input  logic signed [ZW-1:0] z_i,
  output logic                 valid_o,
  output logic                 mode_o,
  output logic signed [XW-1:0] x_o,
  output logic signed [XW-1:0] y_o,
  output logic signed [ZW-1:0] z_o
);

  localparam logic [31:0]        ATAN32 = atan_zw(IDX, ZW);
  localparam logic signed [ZW-1:0] ATAN = ATAN32[ZW-1:0];

  logic                 dir_pos_s;
  logic signed [XW-1:0] x_sh_s, y_sh_s;
  logic signed [XW-1:0] x_d, y_d;
  logic signed [ZW-1:0] z_d;
  logic                 valid_q, mode_q;
  logic signed [XW-1:0] x_q, y_q;
  logic signed [ZW-1:0] z_q;

  // micro-rotation: choose direction, then shift-and-add
  always_comb begin
    x_sh_s = x_i >>> IDX;
    y_sh_s = y_i >>> IDX;
    if (mode_i == VECTOR) begin
      dir_pos_s = y_i[XW-1];
    end else begin
      dir_pos_s = ~z_i[ZW-1];
    end
    if (dir_pos_s) begin
      x_d = x_i - y_sh_s;
      y_d = y_i + x_sh_s;
      z_d = z_i - ATAN;
    end else begin
      x_d = x_i + y_sh_s;
      y_d = y_i - x_sh_s;
      z_d = z_i + ATAN;
    end
  end

  // stage register: advance on enable, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      mode_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      mode_q  <= mode_i;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
    end
  end

  assign valid_o = valid_q;
  assign mode_o  = mode_q;
  assign x_o     = x_q;
  assign y_o     = y_q;
  assign z_o     = z_q;

endmodule

// File: rtl/cordic_pipe.sv
// cordic_pipe: fully pipelined CORDIC (rotation and vectoring, per sample).
// Quadrant pre-rotation register, STAGES micro-rotation registers and, when
// CORDIC_GAIN_COMP_EN is defined, a final 1/K gain-compensation register.
// A single global enable (out_ready | ~out_valid) freezes every stage.
module cordic_pipe
  import cordic_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ZW     = 16,
  parameter int STAGES = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode,
  input  logic signed [WIDTH-1:0] in_x,
  input  logic signed [WIDTH-1:0] in_y,
  input  logic signed [ZW-1:0]    in_z,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_mode,
  output logic signed [WIDTH+1:0] out_x,
  output logic signed [WIDTH+1:0] out_y,
  output logic signed [ZW-1:0]    out_z
);

  localparam int XW = WIDTH + 2;
  // +pi/2 in binary-angle units
  localparam logic signed [ZW-1:0] Z_QTR = $signed({2'b01, {(ZW-2){1'b0}}});

  logic en_s;
  logic signed [XW-1:0] x_ext_s, y_ext_s;
  logic signed [XW-1:0] p_x_d, p_y_d;
  logic signed [ZW-1:0] p_z_d;
  logic                 p_valid_q, p_mode_q;
  logic signed [XW-1:0] p_x_q, p_y_q;
  logic signed [ZW-1:0] p_z_q;

  logic                 v_s [STAGES+1];
  logic                 m_s [STAGES+1];
  logic signed [XW-1:0] x_s [STAGES+1];
  logic signed [XW-1:0] y_s [STAGES+1];
  logic signed [ZW-1:0] z_s [STAGES+1];

  assign en_s     = out_ready | ~out_valid;
  assign in_ready = en_s;
  assign x_ext_s  = {{2{in_x[WIDTH-1]}}, in_x};
  assign y_ext_s  = {{2{in_y[WIDTH-1]}}, in_y};

  // quadrant pre-rotation: bring the vector/angle into the +-pi/2 range
  always_comb begin
    p_x_d = x_ext_s;
    p_y_d = y_ext_s;
    p_z_d = in_z;
    if (in_mode == VECTOR) begin
      if (x_ext_s[XW-1]) begin
        if (!y_ext_s[XW-1]) begin
          p_x_d = y_ext_s;
          p_y_d = -x_ext_s;
          p_z_d = in_z + Z_QTR;
        end else begin
          p_x_d = -y_ext_s;
          p_y_d = x_ext_s;
          p_z_d = in_z - Z_QTR;
        end
      end else begin
        p_x_d = x_ext_s;
        p_y_d = y_ext_s;
        p_z_d = in_z;
      end
    end else begin
      if (in_z >= Z_QTR) begin
        p_x_d = -y_ext_s;
        p_y_d = x_ext_s;
        p_z_d = in_z - Z_QTR;
      end else if (in_z < -Z_QTR) begin
        p_x_d = y_ext_s;
        p_y_d = -x_ext_s;
        p_z_d = in_z + Z_QTR;
      end else begin
        p_x_d = x_ext_s;
        p_y_d = y_ext_s;
        p_z_d = in_z;
      end
    end
  end

  // pre-rotation register; in_ready == en so in_valid is the accept flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid_q <= 1'b0;
      p_mode_q  <= 1'b0;
      p_x_q     <= '0;
      p_y_q     <= '0;
      p_z_q     <= '0;
    end else if (en_s) begin
      p_valid_q <= in_valid;
      p_mode_q  <= in_mode;
      p_x_q     <= p_x_d;
      p_y_q     <= p_y_d;
      p_z_q     <= p_z_d;
    end
  end

  assign v_s[0] = p_valid_q;
  assign m_s[0] = p_mode_q;
  assign x_s[0] = p_x_q;
  assign y_s[0] = p_y_q;
  assign z_s[0] = p_z_q;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    cordic_stage #(
      .XW  (XW),
      .ZW  (ZW),
      .IDX (gi)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (en_s),
      .valid_i (v_s[gi]),
      .mode_i  (m_s[gi]),
      .x_i     (x_s[gi]),
      .y_i     (y_s[gi]),
      .z_i     (z_s[gi]),
      .valid_o (v_s[gi+1]),
      .mode_o  (m_s[gi+1]),
      .x_o     (x_s[gi+1]),
      .y_o     (y_s[gi+1]),
      .z_o     (z_s[gi+1])
    );
  end

`ifdef CORDIC_GAIN_COMP_EN
  localparam int PW = XW + WIDTH + 2;
  localparam logic [31:0]          GAIN32 = gain_const(WIDTH);
  localparam logic signed [PW-1:0] GAIN_S = $signed(PW'(GAIN32));

  logic signed [PW-1:0] gx_wide_s, gy_wide_s;
  logic signed [XW-1:0] g_x_d, g_y_d;
  logic                 g_valid_q, g_mode_q;
  logic signed [XW-1:0] g_x_q, g_y_q;
  logic signed [ZW-1:0] g_z_q;

  // scale by round(2^WIDTH/K) then drop WIDTH fraction bits (floor)
  always_comb begin
    gx_wide_s = PW'(x_s[STAGES]);
    gy_wide_s = PW'(y_s[STAGES]);
    g_x_d     = XW'((gx_wide_s * GAIN_S) >>> WIDTH);
    g_y_d     = XW'((gy_wide_s * GAIN_S) >>> WIDTH);
  end

  // gain-compensation register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_valid_q <= 1'b0;
      g_mode_q  <= 1'b0;
      g_x_q     <= '0;
      g_y_q     <= '0;
      g_z_q     <= '0;
    end else if (en_s) begin
      g_valid_q <= v_s[STAGES];
      g_mode_q  <= m_s[STAGES];
      g_x_q     <= g_x_d;
      g_y_q     <= g_y_d;
      g_z_q     <= z_s[STAGES];
    end
  end

  assign out_valid = g_valid_q;
  assign out_mode  = g_mode_q;
  assign out_x     = g_x_q;
  assign out_y     = g_y_q;
  assign out_z     = g_z_q;
`else
  assign out_valid = v_s[STAGES];
  assign out_mode  = m_s[STAGES];
  assign out_x     = x_s[STAGES];
  assign out_y     = y_s[STAGES];
  assign out_z     = z_s[STAGES];
`endif

endmodule

// File: tb/tb_cordic_pipe.sv
// tb_cordic_pipe: scoreboard bench for cordic_pipe against a floating-point
// trigonometric model. Also honours CORDIC_GAIN_COMP_EN.
module tb_cordic_pipe;

  localparam int WIDTH  = 16;
  localparam int ZW     = 16;
  localparam int STAGES = 14;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT = STAGES + 2;
`else
  localparam int LAT = STAGES + 1;
`endif
  localparam real PI    = 3.14159265358979323846;
  localparam real ASCL  = 65536.0 / (2.0 * PI);

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic                    in_mode = 1'b0;
  logic signed [WIDTH-1:0] in_x = '0;
  logic signed [WIDTH-1:0] in_y = '0;
  logic signed [ZW-1:0]    in_z = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic                    out_mode;
  logic signed [WIDTH+1:0] out_x, out_y;
  logic signed [ZW-1:0]    out_z;

  always #5 clk = ~clk;

  cordic_pipe #(.WIDTH(WIDTH), .ZW(ZW), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
    .out_x(out_x), .out_y(out_y), .out_z(out_z)
  );

  typedef struct {
    logic mode;
    real  ex, ey, ez;
    real  txy, tz;
    int   acc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   chk_lat = 1'b0;
  bit   rnd_ready = 1'b0;
  real  gscale;

  always @(posedge clk) cyc <= cyc + 1;

  // downstream ready: random or always-on, changed just after each edge
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string nm, input real act, input real ex, input real tol);
    n_checks++;
    if (act - ex > tol || ex - act > tol) begin
      n_err++;
      $display("FAIL %s: got %0.2f expected %0.2f (tol %0.2f) t=%0t", nm, act, ex, tol, $time);
    end
  endtask

  task automatic chk_ang(input string nm, input real act, input real ex, input real tol);
    real d;
    d = act - ex;
    while (d > 32768.0) d = d - 65536.0;
    while (d < -32768.0) d = d + 65536.0;
    n_checks++;
    if (d > tol || -d > tol) begin
      n_err++;
      $display("FAIL %s: got %0.2f expected %0.2f mod 2^16 (tol %0.2f) t=%0t", nm, act, ex, tol, $time);
    end
  endtask

  // ideal CORDIC result from plain trigonometry
  function automatic exp_t model(input logic m, input int x, input int y, input int z,
                                 input real txy, input real tz);
    exp_t e;
    real  th, rx, ry;
    rx = real'(x);
    ry = real'(y);
    th = real'(z) / ASCL;
    e.mode = m;
    e.txy  = txy;
    e.tz   = tz;
    e.acc  = 0;
    if (m == 1'b0) begin
      e.ex = gscale * (rx * $cos(th) - ry * $sin(th));
      e.ey = gscale * (rx * $sin(th) + ry * $cos(th));
      e.ez = 0.0;
    end else begin
      e.ex = gscale * $sqrt(rx * rx + ry * ry);
      e.ey = 0.0;
      e.ez = real'(z) + $atan2(ry, rx) * ASCL;
    end
    return e;
  endfunction

  // present one sample; called #1 after a rising edge, returns likewise
  task automatic send(input logic m, input int x, input int y, input int z,
                      input real txy, input real tz);
    exp_t e;
    bit   done;
    e = model(m, x, y, z, txy, tz);
    in_valid = 1'b1;
    in_mode  = m;
    in_x     = WIDTH'(x);
    in_y     = WIDTH'(y);
    in_z     = ZW'(z);
    done = 1'b0;
    for (int t = 0; t < 1000 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        e.acc = cyc;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_checks++;
      n_err++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 1000 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() > 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // monitor: compare every transferred output and check stall behaviour
  initial begin : monitor
    exp_t e;
    bit   hold_v;
    logic signed [WIDTH+1:0] hx, hy;
    logic signed [ZW-1:0]    hz;
    logic                    hm;
    hold_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          n_checks++;
          if (!out_valid || out_x !== hx || out_y !== hy || out_z !== hz || out_mode !== hm) begin
            n_err++;
            $display("FAIL stall_hold: got v=%0b x=%0d y=%0d z=%0d, required held x=%0d y=%0d z=%0d",
                     out_valid, out_x, out_y, out_z, hx, hy, hz);
          end
        end
        if (out_valid && !out_ready) begin
          n_checks++;
          if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL stall_in_ready: got %0b required 0", in_ready);
          end
        end
        hold_v = out_valid && !out_ready;
        hx = out_x; hy = out_y; hz = out_z; hm = out_mode;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_output: got x=%0d y=%0d z=%0d, required no output", out_x, out_y, out_z);
          end else begin
            e = sb.pop_front();
            n_checks++;
            if (out_mode !== e.mode) begin
              n_err++;
              $display("FAIL out_mode: got %0b required %0b", out_mode, e.mode);
            end
            chk("out_x", real'(out_x), e.ex, e.txy);
            chk("out_y", real'(out_y), e.ey, e.txy);
            if (e.mode == 1'b0) chk("out_z_rot", real'(out_z), e.ez, e.tz);
            else chk_ang("out_z_vec", real'(out_z), e.ez, e.tz);
            if (chk_lat) chk("latency", real'(cyc - e.acc), real'(LAT), 0.0);
          end
        end
      end
    end
  end

  initial begin : stimulus
    real  kn, mag;
    int   x, y, z;
    logic m;
    logic signed [15:0] r16;

    kn = 1.0;
    for (int i = 0; i < STAGES; i++) kn = kn * $sqrt(1.0 + $pow(2.0, -2.0 * i));
`ifdef CORDIC_GAIN_COMP_EN
    gscale = kn * $floor(65536.0 / 1.6467602581 + 0.5) / 65536.0;
`else
    gscale = kn;
`endif

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", real'(out_valid), 0.0, 0.0);
    chk("rst_out_x", real'(out_x), 0.0, 0.0);
    chk("rst_out_z", real'(out_z), 0.0, 0.0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", real'(in_ready), 1.0, 0.0);

    // directed points, latency checked
    chk_lat = 1'b1;
    send(1'b0, 16384, 0, 0, 6.0, 6.0);
    send(1'b0, 16384, 0, 16384, 6.0, 6.0);
    send(1'b0, 16384, 0, -32768, 6.0, 6.0);
    send(1'b1, 10000, 10000, 0, 6.0, 2.0);
    send(1'b1, -10000, 0, 0, 6.0, 6.0);
    send(1'b1, -12000, -5000, 1000, 6.0, 6.0);
    send(1'b0, -20000, 7000, -20000, 6.0, 6.0);
    drain();

    // random interleaved modes with random backpressure and bubbles
    chk_lat = 1'b0;
    rnd_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      m = 1'(i % 2);
      do begin
        r16 = 16'($urandom); x = int'(r16);
        r16 = 16'($urandom); y = int'(r16);
        mag = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
      end while (m == 1'b1 && mag < 4096.0);
      r16 = 16'($urandom); z = int'(r16);
      mag = mag * gscale;
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
      if (m == 1'b0) send(m, x, y, z, 8.0 + mag * 3.0e-4, 8.0);
      else send(m, x, y, z, 8.0 + mag * 3.0e-4, 4.0 + ASCL * 20.0 / mag);
    end
    rnd_ready = 1'b0;
    drain();

    // reset while the pipe is full and outputs are flowing
    for (int i = 0; i < 20; i++) begin
      r16 = 16'($urandom); x = int'(r16) / 2;
      r16 = 16'($urandom); z = int'(r16);
      send(1'b0, x, 3000, z, 8.0 + 4.0e-4 * 50000.0, 8.0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", real'(out_valid), 0.0, 0.0);
    chk("midrst_out_x", real'(out_x), 0.0, 0.0);
    chk("midrst_out_y", real'(out_y), 0.0, 0.0);
    chk("midrst_out_z", real'(out_z), 0.0, 0.0);
    chk("midrst_out_mode", real'(out_mode), 0.0, 0.0);
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_in_ready", real'(in_ready), 1.0, 0.0);
    chk_lat = 1'b1;
    send(1'b1, 10000, 10000, 0, 6.0, 2.0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
